// File: rtl/bus_width_decrease_arbiter_if.sv
// Bundle between NUM_REQ wide-word requesters, the arbiter and one narrow beat consumer.
// req_data keeps the flat layout: requester i occupies bits [i*SIZE_IN +: SIZE_IN].
interface bus_width_decrease_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SIZE_IN  = 32,
    parameter int unsigned SIZE_OUT = 8,
    parameter int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0][SIZE_IN-1:0] req_data;
    logic                            output_valid;
    logic                            output_ready;
    logic [SIZE_OUT-1:0]             data_out;
    logic [ID_W-1:0]                 out_id;
    logic                            out_last;

    modport slave (
        input  req_valid, req_data, output_ready,
        output req_ready, output_valid, data_out, out_id, out_last
    );

    modport master (
        output req_valid, req_data, output_ready,
        input  req_ready, output_valid, data_out, out_id, out_last
    );
endinterface

// File: rtl/bus_width_decrease_arbiter.sv
// Round-robin arbiter that serializes one wide requester word at a time into
// SIZE_IN/SIZE_OUT narrow beats, tagged with the source ID and a last-beat flag.
module bus_width_decrease_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SIZE_IN       = 32,
    parameter int unsigned SIZE_OUT      = 8,
    parameter bit          LITTLE_ENDIAN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    bus_width_decrease_arbiter_if.slave  bus
);
    localparam int unsigned BEATS  = SIZE_IN / SIZE_OUT;
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((SIZE_IN % SIZE_OUT) != 0) begin : g_size_check
        $error("SIZE_IN must be a multiple of SIZE_OUT");
    end
    if (NUM_REQ < 2) begin : g_req_check
        $error("NUM_REQ must be at least 2");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                          r_state, w_state_nxt;
    logic [BEATS-1:0][SIZE_OUT-1:0]  r_buf;
    logic [BEAT_W-1:0]               r_beat;
    logic [ID_W-1:0]                 r_id;
    logic [ID_W-1:0]                 r_rr_ptr;

    logic [ID_W-1:0]    w_grant, w_hi, w_lo;
    logic               w_hi_any, w_lo_any;
    logic               w_last_beat, w_xfer, w_slot, w_accept;
    logic [NUM_REQ-1:0] w_ready;
    logic [BEAT_W-1:0]  w_slice;

    // Round-robin search: first valid above the pointer, else first valid overall.
    always_comb begin
        w_hi     = '0;
        w_lo     = '0;
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_hi_any && bus.req_valid[i] && (ID_W'(i) > r_rr_ptr)) begin
                w_hi_any = 1'b1;
                w_hi     = ID_W'(i);
            end
            if (!w_lo_any && bus.req_valid[i]) begin
                w_lo_any = 1'b1;
                w_lo     = ID_W'(i);
            end
        end
        w_grant = w_hi_any ? w_hi : w_lo;
    end

    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_xfer      = (r_state == SEND) && bus.output_ready;
    assign w_slot      = (r_state == IDLE) || (w_xfer && w_last_beat);
    assign w_accept    = w_slot && w_lo_any;

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_xfer && w_last_beat) begin
                    w_state_nxt = w_accept ? SEND : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word buffer, beat counter, source ID and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf    <= '0;
            r_beat   <= '0;
            r_id     <= '0;
            r_rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_buf    <= bus.req_data[w_grant];
            r_beat   <= '0;
            r_id     <= w_grant;
            r_rr_ptr <= w_grant;
        end else if (w_xfer) begin
            r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
        end
    end

    assign w_slice = LITTLE_ENDIAN ? r_beat : (BEAT_W'(BEATS - 1) - r_beat);

    assign bus.req_ready    = w_ready;
    assign bus.output_valid = (r_state == SEND);
    assign bus.data_out     = r_buf[w_slice];
    assign bus.out_id       = r_id;
    assign bus.out_last     = (r_state == SEND) && w_last_beat;
endmodule

// File: tb/tb_bus_width_decrease_arbiter.sv
// Directed self-checking bench: little-endian instance A and big-endian instance B
// share clock and reset; every expected value below is hand-derived.
module tb_bus_width_decrease_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bus_width_decrease_arbiter_if #(.NUM_REQ(4), .SIZE_IN(32), .SIZE_OUT(8)) bus_a ();
    bus_width_decrease_arbiter_if #(.NUM_REQ(4), .SIZE_IN(32), .SIZE_OUT(8)) bus_b ();

    bus_width_decrease_arbiter #(
        .NUM_REQ(4), .SIZE_IN(32), .SIZE_OUT(8), .LITTLE_ENDIAN(1'b1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    bus_width_decrease_arbiter #(
        .NUM_REQ(4), .SIZE_IN(32), .SIZE_OUT(8), .LITTLE_ENDIAN(1'b0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input string tag, input logic [7:0] d, input logic [1:0] id,
                          input logic last);
        check({tag, " valid"}, 32'(bus_a.output_valid), 32'(1'b1));
        check({tag, " data"},  32'(bus_a.data_out),     32'(d));
        check({tag, " id"},    32'(bus_a.out_id),       32'(id));
        check({tag, " last"},  32'(bus_a.out_last),     32'(last));
    endtask

    initial begin
        logic [31:0] word;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_a.req_valid = '0;
        bus_a.req_data = '0;
        bus_a.output_ready = 1'b0;
        bus_b.req_valid = '0;
        bus_b.req_data = '0;
        bus_b.output_ready = 1'b0;
        tick();
        tick();
        #1;
        check("reset valid", 32'(bus_a.output_valid), 32'd0);
        check("reset last",  32'(bus_a.out_last),     32'd0);
        check("reset id",    32'(bus_a.out_id),       32'd0);
        check("reset ready", 32'(bus_a.req_ready),    32'd0);
        rst = 1'b0;
        tick();

        // Single requester on A; big-endian word on B.
        word = 32'hDDCCBBAA;
        bus_a.req_data[2] = word;
        bus_a.req_valid = 4'b0100;
        bus_a.output_ready = 1'b1;
        bus_b.req_data[0] = 32'h11223344;
        bus_b.req_valid = 4'b0001;
        bus_b.output_ready = 1'b1;
        #1;
        check("single ready", 32'(bus_a.req_ready), 32'h4);
        check("single valid pre", 32'(bus_a.output_valid), 32'd0);
        tick();
        bus_a.req_valid = '0;
        bus_b.req_valid = '0;
        for (int b = 0; b < 4; b++) begin
            logic [31:0] sh;
            logic [31:0] bexp;
            sh = word >> (8 * b);
            bexp = 32'h11223344 >> (8 * (3 - b));
            #1;
            beat_a("single", sh[7:0], 2'd2, (b == 3));
            check("be data", 32'(bus_b.data_out), 32'(bexp[7:0]));
            check("be last", 32'(bus_b.out_last), 32'(b == 3));
            check("be id",   32'(bus_b.out_id),   32'd0);
            tick();
        end
        #1;
        check("single idle", 32'(bus_a.output_valid), 32'd0);
        check("be idle",     32'(bus_b.output_valid), 32'd0);

        // Round-robin with all four requesters held valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_a.req_data[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        end
        bus_a.req_valid = 4'hF;
        #1;
        check("rr first ready", 32'(bus_a.req_ready), 32'h1);
        tick();
        for (int n = 0; n < 20; n++) begin
            int w;
            w = n / 4;
            #1;
            beat_a("rr", 8'(4*(w % 4) + (n % 4)), 2'(w % 4), ((n % 4) == 3));
            if ((n % 4) == 3 && n < 19) begin
                check("rr next ready", 32'(bus_a.req_ready), 32'(1 << ((w + 1) % 4)));
            end
            tick();
            if (n == 15) bus_a.req_valid = '0;
        end
        #1;
        check("rr idle", 32'(bus_a.output_valid), 32'd0);

        // Backpressure on beat 1 while another requester waits.
        bus_a.req_data[1] = 32'h44332211;
        bus_a.req_valid = 4'b0010;
        tick();
        bus_a.req_valid = '0;
        #1;
        beat_a("bp b0", 8'h11, 2'd1, 1'b0);
        tick();
        bus_a.output_ready = 1'b0;
        bus_a.req_valid = 4'b1000;
        for (int s = 0; s < 3; s++) begin
            #1;
            beat_a("bp stall", 8'h22, 2'd1, 1'b0);
            check("bp no ready", 32'(bus_a.req_ready), 32'd0);
            tick();
        end
        bus_a.req_valid = '0;
        bus_a.output_ready = 1'b1;
        #1;
        beat_a("bp b1", 8'h22, 2'd1, 1'b0);
        tick();
        #1;
        beat_a("bp b2", 8'h33, 2'd1, 1'b0);
        tick();
        #1;
        beat_a("bp b3", 8'h44, 2'd1, 1'b1);
        tick();

        // Pointer at 1: requester 0 wins over requester 1.
        bus_a.req_data[0] = 32'hA3A2A1A0;
        bus_a.req_valid = 4'b0011;
        #1;
        check("rot ready", 32'(bus_a.req_ready), 32'h1);
        tick();
        bus_a.req_valid = '0;
        #1;
        beat_a("rot b0", 8'hA0, 2'd0, 1'b0);
        tick();
        tick();
        #1;
        beat_a("rot b2", 8'hA2, 2'd0, 1'b0);

        // Reset in the middle of a word.
        rst = 1'b1;
        tick();
        #1;
        check("mid rst valid", 32'(bus_a.output_valid), 32'd0);
        check("mid rst last",  32'(bus_a.out_last),     32'd0);
        rst = 1'b0;
        bus_a.req_data[1] = 32'h0000B1B0;
        bus_a.req_data[3] = 32'h0000D1D0;
        bus_a.req_valid = 4'b1010;
        #1;
        check("post rst ready", 32'(bus_a.req_ready), 32'h2);
        tick();
        #1;
        beat_a("post rst b0", 8'hB0, 2'd1, 1'b0);
        bus_a.req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
